// File: rtl/jtcps1_vram_arb.sv
// jtcps1_vram_arb: one shared VRAM read port for three video readers.
// Channel 0 reads the scroll tile maps, channel 1 the object table and channel 2
// the palette copy. Arbitration is round-robin. pal_prio lets channel 2 win
// every arbitration. Each channel latches its own data, so a re-read of the last
// served address returns at once.
module jtcps1_vram_arb #(
    parameter int AW = 17,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          pal_prio,
    // scroll tile maps
    input  logic          ch0_cs,
    input  logic [AW-1:0] ch0_addr,
    output logic [DW-1:0] ch0_data,
    output logic          ch0_ok,
    // object table
    input  logic          ch1_cs,
    input  logic [AW-1:0] ch1_addr,
    output logic [DW-1:0] ch1_data,
    output logic          ch1_ok,
    // palette copy
    input  logic          ch2_cs,
    input  logic [AW-1:0] ch2_addr,
    output logic [DW-1:0] ch2_data,
    output logic          ch2_ok,
    // shared VRAM port
    output logic [AW-1:0] ram_addr,
    output logic          ram_cs,
    input  logic [DW-1:0] ram_data,
    input  logic          ram_ok,
    output logic [1:0]    gnt
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'd3;

    state_t        state, state_nxt;
    logic          grant;   // IDLE -> BUSY this cycle
    logic          done;    // BUSY -> IDLE this cycle
    logic [1:0]    win;
    logic [1:0]    ptr;     // last channel granted

    logic [2:0]    ch_cs;
    logic [AW-1:0] ch_addr [3];
    logic [AW-1:0] served  [3];
    logic [DW-1:0] data_q  [3];
    logic [2:0]    valid;
    logic [2:0]    hit;
    logic [2:0]    pend;

    assign ch_cs      = {ch2_cs, ch1_cs, ch0_cs};
    assign ch_addr[0] = ch0_addr;
    assign ch_addr[1] = ch1_addr;
    assign ch_addr[2] = ch2_addr;

    // Hit/pending per channel: a valid latch for the current address needs no access
    always_comb begin
        for (int n = 0; n < 3; n++) begin
            hit[n]  = valid[n] && (ch_addr[n] == served[n]);
            pend[n] = ch_cs[n] && !hit[n];
        end
    end

    // ok follows the address compare combinationally, so it drops in the same cycle
    assign ch0_ok   = ch0_cs && hit[0];
    assign ch1_ok   = ch1_cs && hit[1];
    assign ch2_ok   = ch2_cs && hit[2];
    assign ch0_data = data_q[0];
    assign ch1_data = data_q[1];
    assign ch2_data = data_q[2];

    assign ram_cs = (state == BUSY);

    // Winner select: palette override, else first pending channel after ptr
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        win = 2'd0;
        if (pal_prio && pend[2]) begin
            win = 2'd2;
        end else begin
            // Walk the cyclic order backwards so the earliest pending channel is written last
            for (int i = 3; i >= 1; i--) begin
                if (pend[(int'(ptr) + i) % 3]) win = 2'((int'(ptr) + i) % 3);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: grant from IDLE on any pending request, release on ram_ok
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (|pend) begin
                    grant     = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (ram_ok) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture address/grant on entry, latch data and served address on completion
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ram_addr <= '0;
            gnt      <= GNT_NONE;
            ptr      <= 2'd2;
            valid    <= '0;
            // NOTE: the per-channel latches are only three words and must read zero after reset, so they are reset like plain flops.
            for (int n = 0; n < 3; n++) begin
                served[n] <= '0;
                data_q[n] <= '0;
            end
        end else if (grant) begin
            gnt <= win;
            ptr <= win;
            for (int n = 0; n < 3; n++) begin
                if (win == 2'(n)) begin
                    ram_addr <= ch_addr[n];
                    valid[n] <= 1'b0;
                end
            end
        end else if (done) begin
            gnt <= GNT_NONE;
            for (int n = 0; n < 3; n++) begin
                if (gnt == 2'(n)) begin
                    data_q[n] <= ram_data;
                    served[n] <= ram_addr;
                    valid[n]  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtcps1_vram_arb.sv
// tb_jtcps1_vram_arb: directed bench for the VRAM arbiter with a simple VRAM responder.
// The responder answers ram_addr[15:0]+0x1000 (or a fixed word) rsp_lat cycles after ram_cs.
module tb_jtcps1_vram_arb;

    localparam int AW = 17;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          pal_prio;
    logic          ch0_cs, ch1_cs, ch2_cs;
    logic [AW-1:0] ch0_addr, ch1_addr, ch2_addr;
    logic [DW-1:0] ch0_data, ch1_data, ch2_data;
    logic          ch0_ok, ch1_ok, ch2_ok;
    logic [AW-1:0] ram_addr;
    logic          ram_cs;
    logic [DW-1:0] ram_data;
    logic          ram_ok;
    logic [1:0]    gnt;

    // responder controls and state
    logic          rsp_en = 1'b1;
    int            rsp_lat = 1;
    logic          rsp_fixed_en = 1'b0;
    logic [DW-1:0] rsp_fixed = '0;
    logic          rsp_ok = 1'b0;
    logic [DW-1:0] rsp_data = '0;
    int            rsp_cnt = 0;
    logic          force_ok = 1'b0;

    // monitor
    logic [1:0]    grants[$];
    int            pulses = 0;
    logic          prev_cs = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    assign ram_ok   = rsp_ok | force_ok;
    assign ram_data = force_ok ? 16'hDEAD : rsp_data;

    jtcps1_vram_arb #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .pal_prio (pal_prio),
        .ch0_cs   (ch0_cs),
        .ch0_addr (ch0_addr),
        .ch0_data (ch0_data),
        .ch0_ok   (ch0_ok),
        .ch1_cs   (ch1_cs),
        .ch1_addr (ch1_addr),
        .ch1_data (ch1_data),
        .ch1_ok   (ch1_ok),
        .ch2_cs   (ch2_cs),
        .ch2_addr (ch2_addr),
        .ch2_data (ch2_data),
        .ch2_ok   (ch2_ok),
        .ram_addr (ram_addr),
        .ram_cs   (ram_cs),
        .ram_data (ram_data),
        .ram_ok   (ram_ok),
        .gnt      (gnt)
    );

    always #5 clk = ~clk;

    // VRAM responder: raise ram_ok for one cycle rsp_lat cycles into each access
    always @(negedge clk) begin
        if (!rsp_en || !ram_cs) begin
            rsp_cnt = 0;
            rsp_ok  = 1'b0;
        end else begin
            rsp_cnt = rsp_cnt + 1;
            rsp_ok  = (rsp_cnt == rsp_lat);
            if (rsp_cnt == rsp_lat)
                rsp_data = rsp_fixed_en ? rsp_fixed : ram_addr[15:0] + 16'h1000;
        end
    end

    // Grant monitor: log gnt at every rising ram_cs
    always @(negedge clk) begin
        if (ram_cs && !prev_cs) begin
            grants.push_back(gnt);
            pulses = pulses + 1;
        end
        prev_cs = ram_cs;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic ok_of(input int ch);
        case (ch)
            0:       return ch0_ok;
            1:       return ch1_ok;
            default: return ch2_ok;
        endcase
    endfunction

    task automatic wait_ok(input int ch, input int budget, input string tag, output int cycles);
        cycles = 0;
        while (1) begin
            @(negedge clk);
            cycles++;
            if (ok_of(ch)) break;
            if (cycles >= budget) begin
                check({tag, "_timeout"}, 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic do_reset();
        ch0_cs = 0; ch1_cs = 0; ch2_cs = 0;
        ch0_addr = '0; ch1_addr = '0; ch2_addr = '0;
        pal_prio = 0; force_ok = 0; rsp_en = 1; rsp_lat = 1; rsp_fixed_en = 0;
        rstn = 0;
        tick(2);
        check("rst_ram_cs", 32'(ram_cs), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd3);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_data0", 32'(ch0_data), 32'd0);
        rstn = 1;
        tick(1);
    endtask

    task automatic check_grants(input string tag, input int base, input logic [1:0] exp[$]);
        check({tag, "_count"}, 32'(grants.size() - base), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            if (base + i < grants.size())
                check($sformatf("%s_g%0d", tag, i), 32'(grants[base + i]), 32'(exp[i]));
    endtask

    initial begin
        int cyc;
        int base;
        int p0;
        logic [1:0] exp_q[$];

        // 1: single ch0 read, ram_ok three cycles after ram_cs
        do_reset();
        rsp_lat = 3; rsp_fixed_en = 1; rsp_fixed = 16'hBEEF;
        ch0_addr = 17'h00100; ch0_cs = 1;
        tick(1);
        check("t1_ram_cs", 32'(ram_cs), 32'd1);
        check("t1_ram_addr", 32'(ram_addr), 32'h00100);
        check("t1_gnt", 32'(gnt), 32'd0);
        wait_ok(0, 20, "t1_ok", cyc);
        check("t1_latency", 32'(cyc), 32'd3);
        check("t1_data", 32'(ch0_data), 32'hBEEF);
        check("t1_gnt_idle", 32'(gnt), 32'd3);
        ch0_cs = 0; rsp_fixed_en = 0;
        #1 check("t1_ok_drop", 32'(ch0_ok), 32'd0);

        // 2a: three simultaneous requests from reset -> 0,1,2
        do_reset();
        base = grants.size();
        ch0_addr = 17'h10; ch1_addr = 17'h20; ch2_addr = 17'h30;
        ch0_cs = 1; ch1_cs = 1; ch2_cs = 1;
        wait_ok(2, 40, "t2a_ok2", cyc);
        exp_q = '{2'd0, 2'd1, 2'd2};
        check_grants("t2a", base, exp_q);
        check("t2a_ok0", 32'(ch0_ok), 32'd1);
        check("t2a_d0", 32'(ch0_data), 32'h1010);
        check("t2a_d1", 32'(ch1_data), 32'h1020);
        check("t2a_d2", 32'(ch2_data), 32'h1030);

        // 2b: pointer left at 0, then all three pending -> 1,2,0
        do_reset();
        ch0_addr = 17'h40; ch0_cs = 1;
        wait_ok(0, 20, "t2b_pre", cyc);
        base = grants.size();
        ch0_addr = 17'h44; ch1_addr = 17'h50; ch2_addr = 17'h60;
        ch1_cs = 1; ch2_cs = 1;
        wait_ok(0, 40, "t2b_ok0", cyc);
        exp_q = '{2'd1, 2'd2, 2'd0};
        check_grants("t2b", base, exp_q);
        check("t2b_d0", 32'(ch0_data), 32'h1044);

        // 3: palette priority starves ch0 while ch2 keeps requesting
        do_reset();
        pal_prio = 1; rsp_lat = 2;
        base = grants.size();
        ch0_addr = 17'h600; ch2_addr = 17'h500;
        ch0_cs = 1; ch2_cs = 1;
        for (int i = 0; i < 4; i++) begin
            wait_ok(2, 20, "t3_ok2", cyc);
            if (i < 3) ch2_addr = ch2_addr + 17'd4;
            else       ch2_cs = 0;
        end
        wait_ok(0, 20, "t3_ok0", cyc);
        exp_q = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
        check_grants("t3", base, exp_q);
        check("t3_d2", 32'(ch2_data), 32'h150C);
        check("t3_d0", 32'(ch0_data), 32'h1600);

        // 4: address change drops ok at once and re-requests
        do_reset();
        ch1_addr = 17'h00200; ch1_cs = 1;
        wait_ok(1, 20, "t4_pre", cyc);
        check("t4_d_old", 32'(ch1_data), 32'h1200);
        ch1_addr = 17'h00204;
        #1 check("t4_ok_drop", 32'(ch1_ok), 32'd0);
        tick(1);
        check("t4_ram_cs", 32'(ram_cs), 32'd1);
        check("t4_ram_addr", 32'(ram_addr), 32'h00204);
        check("t4_gnt", 32'(gnt), 32'd1);
        wait_ok(1, 20, "t4_ok", cyc);
        check("t4_d_new", 32'(ch1_data), 32'h1204);

        // 5: reset during BUSY, stale ram_ok afterwards is ignored
        do_reset();
        rsp_en = 0;
        ch0_addr = 17'h00300; ch0_cs = 1;
        tick(1);
        check("t5_busy", 32'(ram_cs), 32'd1);
        rstn = 0; ch0_cs = 0;
        tick(1);
        check("t5_rst_cs", 32'(ram_cs), 32'd0);
        check("t5_rst_gnt", 32'(gnt), 32'd3);
        force_ok = 1; rstn = 1;
        tick(1);
        force_ok = 0;
        check("t5_cs_after", 32'(ram_cs), 32'd0);
        check("t5_gnt_after", 32'(gnt), 32'd3);
        check("t5_d0", 32'(ch0_data), 32'd0);
        ch0_cs = 1; rsp_en = 1;
        #1 check("t5_no_ok", 32'(ch0_ok), 32'd0);
        tick(1);
        check("t5_reaccess", 32'(ram_cs), 32'd1);
        wait_ok(0, 20, "t5_ok", cyc);
        check("t5_d0_new", 32'(ch0_data), 32'h1300);

        // 6: cs dropped mid-BUSY, re-raised with the same address -> no new access
        do_reset();
        rsp_lat = 3;
        ch0_addr = 17'h00400; ch0_cs = 1;
        tick(1);
        check("t6_busy", 32'(ram_cs), 32'd1);
        ch0_cs = 0;
        cyc = 0;
        while (ram_cs && cyc < 20) begin
            tick(1);
            cyc++;
        end
        check("t6_done", 32'(ram_cs), 32'd0);
        p0 = pulses;
        ch0_cs = 1;
        #1 check("t6_ok_now", 32'(ch0_ok), 32'd1);
        check("t6_data", 32'(ch0_data), 32'h1400);
        tick(3);
        check("t6_no_pulse", 32'(pulses - p0), 32'd0);
        check("t6_ok_held", 32'(ch0_ok), 32'd1);
        // ram_ok while IDLE changes nothing
        force_ok = 1;
        tick(1);
        force_ok = 0;
        tick(1);
        check("t6_idle_ok_cs", 32'(ram_cs), 32'd0);
        check("t6_idle_ok_gnt", 32'(gnt), 32'd3);
        check("t6_idle_ok_d", 32'(ch0_data), 32'h1400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
